// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory (1-cycle read
// latency) between the instruction-fetch port and the data port.
// Data wins by default; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive denied fetch cycles.
// Optional build macro MEM_ARB_STATS_EN adds stall-cycle counters
// stat_istall / stat_dstall (32 bit, wrapping).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [15:0]       InstrAddr,
  input  logic              InstrRead,
  output logic              InstrWaitreq,
  output logic [DATA_W-1:0] InstrIn,
  input  logic [15:0]       DataAddr,
  input  logic              ReadData,
  input  logic              WriteData,
  input  logic [DATA_W-1:0] DataOut,
  output logic              DataWaitreq,
  output logic [DATA_W-1:0] DataIn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_istall,
  output logic [31:0]       stat_dstall
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    RD_I,
    RD_D
  } ret_state_e;

  ret_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] instr_hold_q, data_hold_q;
  logic              data_req, starved, grant_i, grant_d;

  // Upper address bits are intentionally dropped: addresses wrap inside the memory.
  generate
    if (ADDR_W < 16) begin : g_trunc
      logic unused_hi_addr;
      assign unused_hi_addr = ^{InstrAddr[15:ADDR_W], DataAddr[15:ADDR_W]};
    end
  endgenerate

  // Arbitration, memory-side drive, waitreq outputs and next-state logic.
  always_comb begin
    data_req     = ReadData | WriteData;
    starved      = (starve_q == STARVE_LIM);
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    state_d      = IDLE;
    starve_d     = starve_q;
    mem_addr     = last_addr_q;
    mem_wdata    = DataOut;
    mem_wren     = 1'b0;

    if (Resetn) begin
      if (InstrRead && (starved || !data_req)) begin
        grant_i = 1'b1;
      end else if (data_req) begin
        grant_d = 1'b1;
      end
    end

    InstrWaitreq = !Resetn || (InstrRead && !grant_i);
    DataWaitreq  = !Resetn || (data_req && !grant_d);

    if (grant_i) begin
      mem_addr = InstrAddr[ADDR_W-1:0];
      state_d  = RD_I;
    end else if (grant_d) begin
      mem_addr = DataAddr[ADDR_W-1:0];
      mem_wren = WriteData;
      if (!WriteData) begin
        state_d = RD_D;
      end
    end

    if (!InstrRead || grant_i) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Return routing: mem_q goes to the owner of the previous read, the other holds.
  // Gating with Resetn discards a return that lands in a reset cycle.
  always_comb begin
    InstrIn = instr_hold_q;
    DataIn  = data_hold_q;
    if (Resetn && (state_q == RD_I)) begin
      InstrIn = mem_q;
    end
    if (Resetn && (state_q == RD_D)) begin
      DataIn = mem_q;
    end
  end

  // Return-owner FSM and starvation counter registers.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Held read data and last granted address.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      instr_hold_q <= '0;
      data_hold_q  <= '0;
      last_addr_q  <= '0;
    end else begin
      instr_hold_q <= InstrIn;
      data_hold_q  <= DataIn;
      if (grant_i || grant_d) begin
        last_addr_q <= mem_addr;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_istall_q, stat_dstall_q;

  // Stall-cycle counters; wrap naturally at 2^32.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      stat_istall_q <= '0;
      stat_dstall_q <= '0;
    end else begin
      if (InstrRead && InstrWaitreq) begin
        stat_istall_q <= stat_istall_q + 32'd1;
      end
      if (data_req && DataWaitreq) begin
        stat_dstall_q <= stat_dstall_q + 32'd1;
      end
    end
  end

  assign stat_istall = stat_istall_q;
  assign stat_dstall = stat_dstall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized requests, all checked every cycle against a
// transaction-level model (grant rule, starvation count, reference memory).
module tb_mem_port_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned SM = 4;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic [15:0]   InstrAddr, DataAddr;
  logic          InstrRead, ReadData, WriteData;
  logic [DW-1:0] DataOut, InstrIn, DataIn, mem_wdata, mem_q;
  logic          InstrWaitreq, DataWaitreq, mem_wren;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]   stat_istall, stat_dstall;
`endif

  always #5 Clock = ~Clock;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .InstrAddr(InstrAddr), .InstrRead(InstrRead), .InstrWaitreq(InstrWaitreq), .InstrIn(InstrIn),
    .DataAddr(DataAddr), .ReadData(ReadData), .WriteData(WriteData), .DataOut(DataOut),
    .DataWaitreq(DataWaitreq), .DataIn(DataIn),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q)
`ifdef MEM_ARB_STATS_EN
    , .stat_istall(stat_istall), .stat_dstall(stat_dstall)
`endif
  );

  // Physical memory driven by the DUT.
  logic [DW-1:0] phys_mem [0:4095];
  always @(posedge Clock) begin
    if (mem_wren) phys_mem[mem_addr] <= mem_wdata;
    mem_q <= phys_mem[mem_addr];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:4095];
  int            starve;
  bit            pend_v, pend_is_i, have_last, model_live;
  logic [DW-1:0] pend_val, exp_iin, exp_din;
  logic [AW-1:0] last_addr;
  logic [31:0]   exp_ist, exp_dst;
  int            n_cmp, n_fail;

  // Values sampled in the most recent step.
  logic          s_iw, s_dw, s_wren;
  logic [DW-1:0] s_iin, s_din;
  logic [AW-1:0] s_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against model, then advance model past the edge.
  task automatic step(input logic ir, input logic [15:0] ia, input logic rd, input logic wr,
                      input logic [15:0] da, input logic [DW-1:0] dout, input logic rn);
    bit dreq, gi, gd;
    @(negedge Clock);
    InstrRead = ir; InstrAddr = ia; ReadData = rd; WriteData = wr;
    DataAddr = da; DataOut = dout; Resetn = rn;
    #1;
    dreq = rd | wr;
    gi = 1'b0; gd = 1'b0;
    if (rn) begin
      if (ir && (starve == int'(SM) || !dreq)) gi = 1'b1;
      else if (dreq) gd = 1'b1;
      if (pend_v) begin
        if (pend_is_i) exp_iin = pend_val;
        else exp_din = pend_val;
      end
    end
    s_iw = InstrWaitreq; s_dw = DataWaitreq; s_wren = mem_wren;
    s_iin = InstrIn; s_din = DataIn; s_addr = mem_addr;
    if (model_live) begin
      check("InstrWaitreq", 32'(InstrWaitreq), 32'(!rn || (ir && !gi)));
      check("DataWaitreq", 32'(DataWaitreq), 32'(!rn || (dreq && !gd)));
      check("mem_wren", 32'(mem_wren), 32'(gd && wr));
      if (gi) check("mem_addr_i", 32'(mem_addr), 32'(ia[AW-1:0]));
      else if (gd) check("mem_addr_d", 32'(mem_addr), 32'(da[AW-1:0]));
      else if (have_last && rn) check("mem_addr_hold", 32'(mem_addr), 32'(last_addr));
      if (gd && wr) check("mem_wdata", 32'(mem_wdata), 32'(dout));
      check("InstrIn", 32'(InstrIn), 32'(exp_iin));
      check("DataIn", 32'(DataIn), 32'(exp_din));
`ifdef MEM_ARB_STATS_EN
      check("stat_istall", stat_istall, exp_ist);
      check("stat_dstall", stat_dstall, exp_dst);
`endif
    end
    pend_v = 1'b0;
    if (!rn) begin
      starve = 0; exp_iin = '0; exp_din = '0; have_last = 1'b0;
      exp_ist = '0; exp_dst = '0; model_live = 1'b1;
    end else begin
      if (ir && !gi) exp_ist = exp_ist + 32'd1;
      if (dreq && !gd) exp_dst = exp_dst + 32'd1;
      if (gi) begin
        pend_v = 1'b1; pend_is_i = 1'b1; pend_val = ref_mem[ia[AW-1:0]];
        last_addr = ia[AW-1:0]; have_last = 1'b1;
      end else if (gd) begin
        last_addr = da[AW-1:0]; have_last = 1'b1;
        if (wr) ref_mem[da[AW-1:0]] = dout;
        else begin
          pend_v = 1'b1; pend_is_i = 1'b0; pend_val = ref_mem[da[AW-1:0]];
        end
      end
      if (!ir || gi) starve = 0;
      else if (starve < int'(SM)) starve++;
    end
  endtask

  logic          r_ir, r_rd, r_wr, r_rn;
  logic [15:0]   r_ia, r_da;
  logic [DW-1:0] r_dout;
  logic          prev_iw, prev_dw;
  int            rst_left;

  initial begin
    n_cmp = 0; n_fail = 0;
    starve = 0; pend_v = 1'b0; pend_is_i = 1'b0; have_last = 1'b0; model_live = 1'b0;
    pend_val = '0; exp_iin = '0; exp_din = '0; last_addr = '0; exp_ist = '0; exp_dst = '0;
    for (int i = 0; i < 4096; i++) begin
      phys_mem[i] = 16'(i) ^ 16'hA500;
      ref_mem[i]  = 16'(i) ^ 16'hA500;
    end
    phys_mem[12'h020] = 16'hBEEF;
    ref_mem[12'h020]  = 16'hBEEF;

    // Reset with requests pending: both stalled, no write.
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    check("rst_iwait", 32'(s_iw), 32'd1);
    check("rst_dwait", 32'(s_dw), 32'd1);
    step(1'b1, 16'h0, 1'b1, 1'b1, 16'h7, 16'h9999, 1'b0);
    check("rst_wren", 32'(s_wren), 32'd0);
    step(1'b1, 16'h0, 1'b1, 1'b1, 16'h7, 16'h9999, 1'b0);
    check("rst_instrin", 32'(s_iin), 32'd0);
    check("rst_datain", 32'(s_din), 32'd0);

    // Fetch stream 0,1,2 with no data traffic.
    step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("f0_wait", 32'(s_iw), 32'd0);
    step(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("f1_wait", 32'(s_iw), 32'd0);
    check("f0_data", 32'(s_iin), 32'hA500);
    step(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("f1_data", 32'(s_iin), 32'hA501);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("f2_data", 32'(s_iin), 32'hA502);

    // Store beats a concurrent fetch.
    step(1'b1, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h1234, 1'b1);
    check("st_iwait", 32'(s_iw), 32'd1);
    check("st_dwait", 32'(s_dw), 32'd0);
    check("st_wren", 32'(s_wren), 32'd1);
    check("st_addr", 32'(s_addr), 32'h010);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("st_fetch_retry", 32'(s_iw), 32'd0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("st_readback", 32'(s_din), 32'h1234);

    // Continuous loads starve fetch for exactly STARVE_MAX cycles.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b1);
      if (k <= 4) check("starve_denied", 32'(s_iw), 32'd1);
      else begin
        check("starve_forced", 32'(s_iw), 32'd0);
        check("starve_dwait", 32'(s_dw), 32'd1);
      end
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b1);
    check("forced_fetch_data", 32'(s_iin), 32'hA505);
    step(1'b1, 16'h0003, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("load_beef", 32'(s_din), 32'hBEEF);
    check("instr_unchanged", 32'(s_iin), 32'hA505);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("fetch3_data", 32'(s_iin), 32'hA503);

    // Reset with a load return pending.
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0021, 16'h0, 1'b1);
    step(1'b1, 16'h0000, 1'b1, 1'b1, 16'h0021, 16'h5555, 1'b0);
    check("rstmid_iwait", 32'(s_iw), 32'd1);
    check("rstmid_dwait", 32'(s_dw), 32'd1);
    check("rstmid_wren", 32'(s_wren), 32'd0);
    step(1'b1, 16'h0000, 1'b1, 1'b1, 16'h0021, 16'h5555, 1'b0);
    check("rstmid_datain", 32'(s_din), 32'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("rstmid_discard", 32'(s_din), 32'd0);

    // Randomized traffic; denied requests are usually held, sometimes dropped.
    r_ir = 1'b0; r_rd = 1'b0; r_wr = 1'b0; r_ia = '0; r_da = '0; r_dout = '0;
    prev_iw = 1'b0; prev_dw = 1'b0; rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!(r_ir && prev_iw && r_rn && ($urandom % 8 != 0))) begin
        r_ir = ($urandom % 4 != 0);
        r_ia = 16'($urandom) & 16'hF0FF;
      end
      if (!((r_rd || r_wr) && prev_dw && r_rn && ($urandom % 8 != 0))) begin
        case ($urandom % 8)
          0, 1, 2: begin r_rd = 1'b0; r_wr = 1'b0; end
          3, 4, 5: begin r_rd = 1'b1; r_wr = 1'b0; end
          6:       begin r_rd = 1'b0; r_wr = 1'b1; end
          default: begin r_rd = 1'b1; r_wr = 1'b1; end
        endcase
        r_da   = 16'($urandom) & 16'hF03F;
        r_dout = 16'($urandom);
      end
      if (rst_left > 0) rst_left--;
      else if ($urandom % 256 == 0) rst_left = int'($urandom_range(2, 1));
      r_rn = (rst_left == 0);
      step(r_ir, r_ia, r_rd, r_wr, r_da, r_dout, r_rn);
      prev_iw = s_iw; prev_dw = s_dw;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
